// File: rtl/servo_position_sequencer.sv
// Position-code sequencer feeding the servo PWM stage: button-stepped or timed sweep,
// with every code change landing on a PWM frame boundary.
module servo_position_sequencer #(
    parameter int unsigned DEBOUNCE_TICKS = 500000,
    parameter int unsigned DWELL_FRAMES   = 50
) (
    input  logic        d_in_clk,
    input  logic        d_reset,
    input  logic        d_enable,
    input  logic        d_mode,
    input  logic        d_btn_next,
    input  logic [31:0] n_current_N_clks,
    output logic [7:0]  d_duty_cycle,
    output logic        d_frame_tick,
    output logic        d_pos_changed
);

    typedef enum logic [1:0] {
        S_CTR_A,
        S_PLUS,
        S_CTR_B,
        S_MINUS
    } state_t;

    localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_TICKS - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] prev_cnt;
    logic [31:0] db_cnt;
    logic        btn_meta;
    logic        btn_sync;
    logic        btn_deb;
    logic        btn_deb_q;
    logic        mode_q;
    logic        pending;
    logic        pending_next;
    logic [15:0] dwell;
    logic [15:0] dwell_next;
    logic [15:0] dwell_base;
    logic        boundary;
    logic        press;
    logic        mode_changed;
    logic        advance;
    logic [7:0]  duty_next;

    // Button path keeps running while disabled so the debounced level stays current.
    always_ff @(posedge d_in_clk) begin
        if (d_reset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_meta  <= d_btn_next;
            btn_sync  <= btn_meta;
            btn_deb_q <= btn_deb;
            if (btn_sync == btn_deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_deb <= btn_sync;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 32'd1;
            end
        end
    end

    assign press        = btn_deb & ~btn_deb_q;
    assign boundary     = d_enable && (n_current_N_clks == '0) && (prev_cnt != '0);
    assign mode_changed = d_enable && (d_mode != mode_q);

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_next   = state;
        pending_next = pending;
        dwell_next   = dwell;
        dwell_base   = mode_changed ? 16'd0 : dwell;
        advance      = 1'b0;
        duty_next    = 8'd0;

        if (d_enable) begin
            if (d_mode) begin
                pending_next = 1'b0;
                dwell_next   = dwell_base;
                if (boundary) begin
                    if (dwell_base == DWELL_LAST) begin
                        advance    = 1'b1;
                        dwell_next = '0;
                    end else begin
                        dwell_next = dwell_base + 16'd1;
                    end
                end
            end else begin
                dwell_next = '0;
                if (mode_changed) begin
                    pending_next = 1'b0;
                end else if (boundary && (pending || press)) begin
                    advance      = 1'b1;
                    pending_next = 1'b0;
                end else if (press) begin
                    pending_next = 1'b1;
                end
            end
        end

        if (advance) begin
            case (state)
                S_CTR_A: state_next = S_PLUS;
                S_PLUS:  state_next = S_CTR_B;
                S_CTR_B: state_next = S_MINUS;
                S_MINUS: state_next = S_CTR_A;
                default: state_next = S_CTR_A;
            endcase
        end

        // Decoding the next state lets the code register move on the same edge as the state.
        case (state_next)
            S_PLUS:  duty_next = 8'd2;
            S_MINUS: duty_next = 8'd1;
            default: duty_next = 8'd0;
        endcase
    end

    always_ff @(posedge d_in_clk) begin
        if (d_reset) begin
            state         <= S_CTR_A;
            d_duty_cycle  <= 8'd0;
            d_frame_tick  <= 1'b0;
            d_pos_changed <= 1'b0;
            prev_cnt      <= '0;
            mode_q        <= 1'b0;
            pending       <= 1'b0;
            dwell         <= '0;
        end else begin
            state         <= state_next;
            d_duty_cycle  <= duty_next;
            d_frame_tick  <= boundary;
            d_pos_changed <= advance;
            pending       <= pending_next;
            dwell         <= dwell_next;
            if (d_enable) begin
                prev_cnt <= n_current_N_clks;
                mode_q   <= d_mode;
            end
        end
    end

endmodule

// File: tb/tb_servo_position_sequencer.sv
// Bench for servo_position_sequencer: scenario table, hand-timed corner cases and a
// randomized phase, all checked every cycle against a behavioural model.
module tb_servo_position_sequencer;

    localparam int DB     = 8;
    localparam int DW     = 3;
    localparam int PERIOD = 100;

    typedef enum int {K_NONE, K_PRESS, K_TWO, K_BOUNCE, K_GLITCH} kind_t;

    typedef struct {
        bit         mode;
        bit         en;
        kind_t      kind;
        int         frames;
        logic [7:0] duty;
        int         ticks;
        int         chgs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        btn;
    logic [31:0] fc;
    logic [7:0]  duty;
    logic        tick;
    logic        chg;

    int total = 0;
    int bad   = 0;
    int seen_ticks;
    int seen_chg;
    int hold;
    bit fc_freeze;
    bit ok;
    vec_t tbl [16];

    always #5 clk = ~clk;

    servo_position_sequencer #(
        .DEBOUNCE_TICKS(DB),
        .DWELL_FRAMES  (DW)
    ) dut (
        .d_in_clk        (clk),
        .d_reset         (rst),
        .d_enable        (en),
        .d_mode          (mode),
        .d_btn_next      (btn),
        .n_current_N_clks(fc),
        .d_duty_cycle    (duty),
        .d_frame_tick    (tick),
        .d_pos_changed   (chg)
    );

    function automatic logic [7:0] code_of(input int idx);
        case (idx % 4)
            1:       return 8'd2;
            3:       return 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    // Reference model: position index into the 0,+90,0,-90 sweep, raw button delayed
    // two clocks, debounced level flips once the last DB synced samples all disagree.
    logic [7:0] exp_duty;
    logic       exp_tick;
    logic       exp_chg;
    bit         m_sq [$];
    bit         m_win [$];
    bit         m_deb, m_deb_last, m_mode_q, m_pend;
    bit         m_press, m_bnd, m_mchg, m_adv, m_synced, m_alldiff;
    int         m_dwell, m_idx, m_base;
    logic [31:0] m_prev;

    always @(posedge clk) begin
        if (rst) begin
            m_sq.delete();
            m_sq.push_back(1'b0);
            m_sq.push_back(1'b0);
            m_win.delete();
            for (int i = 0; i < DB; i++) m_win.push_back(1'b0);
            m_deb = 0; m_deb_last = 0; m_mode_q = 0; m_pend = 0;
            m_dwell = 0; m_idx = 0; m_prev = 0;
            exp_duty = 8'd0; exp_tick = 1'b0; exp_chg = 1'b0;
        end else begin
            m_press = m_deb && !m_deb_last;
            m_bnd   = en && (fc == 0) && (m_prev != 0);
            m_mchg  = en && (mode != m_mode_q);
            m_adv   = 0;
            if (en) begin
                if (mode) begin
                    m_pend = 0;
                    m_base = m_mchg ? 0 : m_dwell;
                    if (m_bnd && m_base == DW - 1) begin
                        m_adv   = 1;
                        m_dwell = 0;
                    end else begin
                        m_dwell = m_bnd ? m_base + 1 : m_base;
                    end
                end else begin
                    m_dwell = 0;
                    if (m_mchg) m_pend = 0;
                    else if (m_bnd && (m_pend || m_press)) begin
                        m_adv  = 1;
                        m_pend = 0;
                    end else if (m_press) m_pend = 1;
                end
                m_mode_q = mode;
                m_prev   = fc;
            end
            if (m_adv) m_idx = (m_idx + 1) % 4;
            exp_tick = m_bnd;
            exp_chg  = m_adv;
            exp_duty = code_of(m_idx);

            m_synced = m_sq.pop_front();
            m_sq.push_back(btn);
            void'(m_win.pop_front());
            m_win.push_back(m_synced);
            m_alldiff = 1;
            foreach (m_win[i]) if (m_win[i] == m_deb) m_alldiff = 0;
            m_deb_last = m_deb;
            if (m_alldiff) m_deb = !m_deb;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // One clock: compare against the model after the edge, then advance bench inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        check("model", {duty, tick, chg}, {exp_duty, exp_tick, exp_chg});
        if (tick === 1'b1) seen_ticks++;
        if (chg === 1'b1) seen_chg++;
        if (hold > 0) begin
            hold--;
            if (hold == 0) btn = 1'b0;
        end
        if (!fc_freeze) fc = (fc == PERIOD - 1) ? 32'd0 : fc + 32'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic goto_fc(input int v);
        int g = 0;
        while (fc != v && g < 2 * PERIOD) begin
            cyc();
            g++;
        end
    endtask

    task automatic wait_tick(output bit found);
        found = 0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            cyc();
            if (tick === 1'b1) found = 1;
        end
    endtask

    function automatic bit pat(input kind_t k, input int t);
        case (k)
            K_PRESS:  return (t >= 5 && t < 25);
            K_TWO:    return (t >= 5 && t < 25) || (t >= 45 && t < 65);
            K_BOUNCE: return (t < 60) ? ((t % 8) < 5) : (t < 80);
            K_GLITCH: return (t < 60) && ((t % 10) < 7);
            default:  return 1'b0;
        endcase
    endfunction

    initial begin
        int rnd_left;

        tbl[0]  = '{0, 1, K_NONE,   5, 8'd0, 5, 0};
        tbl[1]  = '{0, 1, K_PRESS,  1, 8'd2, 1, 1};
        tbl[2]  = '{0, 1, K_PRESS,  1, 8'd0, 1, 1};
        tbl[3]  = '{0, 1, K_PRESS,  1, 8'd1, 1, 1};
        tbl[4]  = '{0, 1, K_PRESS,  1, 8'd0, 1, 1};
        tbl[5]  = '{0, 1, K_TWO,    1, 8'd2, 1, 1};
        tbl[6]  = '{0, 1, K_NONE,   2, 8'd2, 2, 0};
        tbl[7]  = '{0, 1, K_BOUNCE, 1, 8'd0, 1, 1};
        tbl[8]  = '{0, 1, K_GLITCH, 1, 8'd0, 1, 0};
        tbl[9]  = '{1, 1, K_NONE,   3, 8'd1, 3, 1};
        tbl[10] = '{1, 1, K_PRESS,  2, 8'd1, 2, 0};
        tbl[11] = '{1, 0, K_NONE,   4, 8'd1, 0, 0};
        tbl[12] = '{1, 1, K_NONE,   1, 8'd0, 1, 1};
        tbl[13] = '{1, 1, K_NONE,   1, 8'd0, 1, 0};
        tbl[14] = '{0, 1, K_NONE,   2, 8'd0, 2, 0};
        tbl[15] = '{0, 1, K_PRESS,  1, 8'd2, 1, 1};

        rst = 1'b1; en = 1'b1; mode = 1'b0; btn = 1'b0;
        fc = 32'd0; fc_freeze = 1'b0; hold = 0; seen_ticks = 0; seen_chg = 0;
        run(3);
        check("reset_duty", duty, 0);
        check("reset_tick", tick, 0);
        check("reset_chg", chg, 0);
        rst = 1'b0;
        goto_fc(1);

        foreach (tbl[v]) begin
            mode = tbl[v].mode;
            en   = tbl[v].en;
            seen_ticks = 0;
            seen_chg   = 0;
            for (int t = 0; t < tbl[v].frames * PERIOD; t++) begin
                btn = pat(tbl[v].kind, t);
                cyc();
            end
            btn = 1'b0;
            check($sformatf("vec%0d_duty", v), duty, tbl[v].duty);
            check($sformatf("vec%0d_ticks", v), seen_ticks, tbl[v].ticks);
            check($sformatf("vec%0d_changes", v), seen_chg, tbl[v].chgs);
        end

        // Press maturing exactly in the boundary cycle is applied at that boundary.
        goto_fc(90);
        btn = 1'b1; hold = 20;
        wait_tick(ok);
        check("coinc_tick_seen", ok, 1);
        check("coinc_changed", chg, 1);
        check("coinc_duty", duty, 0);

        // One cycle later it waits for the following boundary.
        goto_fc(91);
        btn = 1'b1; hold = 20;
        wait_tick(ok);
        check("late_tick_seen", ok, 1);
        check("late_changed_first", chg, 0);
        check("late_duty_first", duty, 0);
        wait_tick(ok);
        check("late_tick2_seen", ok, 1);
        check("late_changed_second", chg, 1);
        check("late_duty_second", duty, 1);

        // Auto sweep from reset: each code held three frames.
        mode = 1'b1;
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        check("auto_reset_duty", duty, 0);
        seen_chg = 0;
        for (int k = 1; k <= 14; k++) begin
            wait_tick(ok);
            check($sformatf("auto_tick%0d_seen", k), ok, 1);
            check($sformatf("auto_tick%0d_duty", k), duty, code_of(k / 3));
        end
        check("auto_changes", seen_chg, 4);
        wait_tick(ok);
        check("auto_tick15_duty", duty, 2);

        // Reset mid-frame clears the code on the very next edge.
        goto_fc(50);
        rst = 1'b1;
        cyc();
        check("midreset_duty", duty, 0);
        check("midreset_tick", tick, 0);
        check("midreset_chg", chg, 0);
        rst = 1'b0;

        // Counter parked at zero: one boundary on entry, none afterwards, none after reset.
        mode = 1'b0;
        run(5);
        fc_freeze = 1'b1;
        fc = 32'd0;
        seen_ticks = 0;
        run(10);
        check("parked_ticks", seen_ticks, 1);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        seen_ticks = 0;
        run(5);
        check("parked_after_reset_ticks", seen_ticks, 0);
        fc_freeze = 1'b0;

        // Randomized phase against the model.
        rnd_left = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = ~mode;
            if ($urandom_range(0, 299) == 0) en = ~en;
            rst = ($urandom_range(0, 999) == 0);
            rnd_left--;
            if (rnd_left <= 0) begin
                btn = ~btn;
                rnd_left = $urandom_range(1, 20);
            end
            fc_freeze = ($urandom_range(0, 99) < 3);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
